// File: rtl/seg_pkg.sv
// Shared types and constants for the binary-to-BCD converter feeding the 7-segment driver.
package seg_pkg;

    localparam int BIN_W   = 14;
    localparam int DIGITS  = 4;
    localparam int BCD_MAX = 9999;
    localparam int CNT_W   = 4;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int SR_W    = BIN_W + BCD_W;

    localparam logic [BCD_W-1:0] BCD_SAT     = 16'h9999;
    localparam logic [BIN_W-1:0] BCD_MAX_BIN = BIN_W'(BCD_MAX);
    localparam logic [CNT_W-1:0] LAST_ITER   = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the next shift.
module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
    end

endmodule

// File: rtl/bin2bcd_4digit.sv
// Sequential 14-bit binary to 4-digit packed BCD converter with START/BUSY/DONE handshake.
// Optional leading-zero blanking mask enabled by defining LEADING_ZERO_BLANK_EN.
//
//   state | meaning
//   IDLE  | waiting for START; outputs hold last result
//   SHIFT | one add-3/shift iteration per cycle, 14 in total
//   FIN   | publish result, pulse DONE; a new START is accepted here
module bin2bcd_4digit
    import seg_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic [BIN_W-1:0]   BIN,
    output logic               BUSY,
    output logic               DONE,
    output logic [BCD_W-1:0]   BCD,
    output logic               OVF,
    output logic [DIGITS-1:0]  BLANK
);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic               accept;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_add3 u_add3 (
            .nib_in  (sr_q[BIN_W + 4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        accept     = START && ((state_q == IDLE) || (state_q == FIN));

        case (state_q)
            IDLE: ;
            SHIFT: begin
                // The top BCD bit falls off the end; that only happens for inputs that saturate anyway.
                sr_d  = {bcd_adj, sr_q[BIN_W-1:0]} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bcd_d   = ovf_pend_q ? BCD_SAT : sr_q[SR_W-1:BIN_W];
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            sr_d       = {{BCD_W{1'b0}}, BIN};
            cnt_d      = '0;
            ovf_pend_d = (BIN > BCD_MAX_BIN);
            busy_d     = 1'b1;
            state_d    = SHIFT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign BCD  = bcd_q;
    assign OVF  = ovf_q;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Scan from the most significant digit; digit 0 always stays lit.
    function automatic logic [DIGITS-1:0] lead_zero_mask(input logic [BCD_W-1:0] d);
        logic [DIGITS-1:0] m;
        logic              seen;
        m    = '0;
        seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0) begin
                seen = 1'b1;
            end
            if (!seen) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    always_comb begin
        blank_d = blank_q;
        if (state_q == FIN) begin
            blank_d = lead_zero_mask(bcd_d);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign BLANK = blank_q;
`else
    assign BLANK = '0;
`endif

endmodule
